// File: rtl/fetch_stage_pkg.sv
// Shared opcode constants and fetch-state encoding for the front end.
package fetch_stage_pkg;

  // Opcodes the fetch stage must recognise on its own.
  localparam logic [4:0]  OP_HALT   = 5'b00000;
  localparam logic [4:0]  OP_NOP    = 5'b00001;

  // Bubble instruction: opcode OP_NOP with all other fields zero.
  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'd0};

  // Fetch controller state encoding (2 bits).
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // True when the instruction word carries the HALT opcode.
  function automatic logic is_halt(input logic [15:0] instr);
    return (instr[15:11] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: 16-bit, load or hold, async active-low reset.
module pc_reg #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] pc_q;

  // Load a new PC when asked, otherwise keep the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else if (load_i) begin
      pc_q <= d_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, memory handshake, one-entry skid
// buffer for data returning under stall, HALT detection and redirect flush.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] ifid_instr,
  output logic [4:0]  ifid_opcode,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  fetch_state_e state_q;
  logic [15:0]  ifid_instr_q;
  logic [15:0]  ifid_pc_plus2_q;
  logic         ifid_valid_q;
  logic         halted_q;
  logic         skid_valid_q;
  logic [15:0]  skid_data_q;
  // Low for one cycle after reset release and after a redirect that
  // cancels a WAIT, so the memory sees a clean idle cycle.
  logic         req_gate_q;

  logic [15:0]  pc_q;
  logic [15:0]  pc_d;
  logic         pc_load_s;
  logic [15:0]  pc_plus2_s;

  logic         fetch_req_s;
  logic         complete_s;
  logic         capture_s;
  logic         deliver_skid_s;
  logic         deliver_mem_s;
  logic         deliver_s;
  logic [15:0]  deliver_instr_s;
  logic         deliver_halt_s;

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(pc_load_s),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  assign pc_plus2_s = pc_q + 16'd2;

  // Request generation and delivery decode for the current cycle.
  always_comb begin
    fetch_req_s     = 1'b0;
    complete_s      = 1'b0;
    capture_s       = 1'b0;
    deliver_skid_s  = 1'b0;
    deliver_mem_s   = 1'b0;
    deliver_s       = 1'b0;
    deliver_instr_s = NOP_INSTR;
    deliver_halt_s  = 1'b0;

    case (state_q)
      ST_FETCH:  fetch_req_s = req_gate_q && !stall && !skid_valid_q;
      ST_WAIT:   fetch_req_s = req_gate_q;
      ST_HALTED: fetch_req_s = 1'b0;
      default:   fetch_req_s = 1'b0;
    endcase

    complete_s     = fetch_req_s && imem_ready;
    capture_s      = complete_s && stall;
    deliver_skid_s = skid_valid_q && !stall;
    deliver_mem_s  = complete_s && !stall;
    deliver_s      = deliver_skid_s || deliver_mem_s;

    if (deliver_skid_s) begin
      deliver_instr_s = skid_data_q;
    end else if (deliver_mem_s) begin
      deliver_instr_s = imem_rdata;
    end else begin
      deliver_instr_s = NOP_INSTR;
    end

    deliver_halt_s = deliver_s && is_halt(deliver_instr_s);
  end

  // Next PC: redirect wins, otherwise advance on any non-HALT delivery.
  always_comb begin
    pc_load_s = 1'b0;
    pc_d      = pc_q;
    if (redirect) begin
      pc_load_s = 1'b1;
      pc_d      = {redirect_pc[15:1], 1'b0};
    end else if (deliver_s && !deliver_halt_s) begin
      pc_load_s = 1'b1;
      pc_d      = pc_plus2_s;
    end else begin
      pc_load_s = 1'b0;
      pc_d      = pc_q;
    end
  end

  // Fetch FSM with IF/ID, skid buffer and halt flag as registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_FETCH;
      ifid_instr_q    <= NOP_INSTR;
      ifid_pc_plus2_q <= 16'h0000;
      ifid_valid_q    <= 1'b0;
      halted_q        <= 1'b0;
      skid_valid_q    <= 1'b0;
      skid_data_q     <= NOP_INSTR;
      req_gate_q      <= 1'b0;
    end else begin
      req_gate_q <= !(redirect && (state_q == ST_WAIT));

      if (redirect) begin
        state_q      <= ST_FETCH;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
        halted_q     <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        // Skid buffer: fill on stalled completion, empty when drained.
        if (capture_s) begin
          skid_valid_q <= 1'b1;
          skid_data_q  <= imem_rdata;
        end else if (deliver_skid_s) begin
          skid_valid_q <= 1'b0;
        end else begin
          skid_valid_q <= skid_valid_q;
        end

        // IF/ID moves only when the downstream stage is not stalled.
        if (!stall) begin
          if (deliver_s) begin
            ifid_instr_q    <= deliver_instr_s;
            ifid_pc_plus2_q <= pc_plus2_s;
            ifid_valid_q    <= 1'b1;
          end else begin
            ifid_instr_q    <= NOP_INSTR;
            ifid_valid_q    <= 1'b0;
          end
        end else begin
          ifid_instr_q <= ifid_instr_q;
          ifid_valid_q <= ifid_valid_q;
        end

        case (state_q)
          ST_FETCH: begin
            if (deliver_halt_s) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else if (fetch_req_s && !imem_ready) begin
              state_q <= ST_WAIT;
            end else begin
              state_q <= ST_FETCH;
            end
          end
          ST_WAIT: begin
            if (deliver_halt_s) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else if (complete_s) begin
              state_q <= ST_FETCH;
            end else begin
              state_q <= ST_WAIT;
            end
          end
          ST_HALTED: begin
            state_q <= ST_HALTED;
          end
          default: begin
            state_q <= ST_FETCH;
          end
        endcase
      end
    end
  end

  assign imem_req      = fetch_req_s;
  assign imem_addr     = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_opcode   = ifid_instr_q[15:11];
  assign ifid_pc_plus2 = ifid_pc_plus2_q;
  assign ifid_valid    = ifid_valid_q;
  assign halted        = halted_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0800: bubble instruction with opcode 00001, which decodes as Nop.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard hold; IF/ID and PC frozen.
REQ-006 redirect  input  1  taken branch or jump from a later stage.
REQ-007 redirect_pc  input  16  new fetch address; bit 0 is forced to 0.
REQ-008 imem_req  output  1  instruction-memory read request.
REQ-009 imem_addr  output  16  read address, always equal to the current PC.
REQ-010 imem_rdata  input  16  read data, valid when imem_ready=1.
REQ-011 imem_ready  input  1  read completes this cycle.
REQ-012 ifid_instr  output  16  IF/ID instruction register.
REQ-013 ifid_opcode  output  5  ifid_instr[15:11], fed to the decoder.
REQ-014 ifid_pc_plus2  output  16  PC+2 of the instruction held in IF/ID.
REQ-015 ifid_valid  output  1  IF/ID holds a real instruction.
REQ-016 halted  output  1  a HALT instruction has been fetched; fetching has stopped.

Function
REQ-017 States are FETCH, WAIT and HALTED; the block encodes state in 2 bits.
REQ-018 In FETCH, imem_req = !stall and imem_addr = PC.
REQ-019 FETCH with stall=0 and imem_ready=0 moves to WAIT; WAIT holds imem_req=1 and a stable address until imem_ready=1.
REQ-020 On completion with stall=0, the block loads IF/ID as {imem_rdata, PC+2, valid=1}, sets PC to PC+2 (modulo 2^16, so 16'hFFFE wraps to 16'h0000), and returns to FETCH; latency is 1 cycle from imem_ready to ifid_valid.
REQ-021 On completion with stall=1, the block captures the data in a one-entry skid buffer and does not advance PC; the buffer drains into IF/ID on the first cycle with stall=0, and no new request issues while the buffer is full.
REQ-022 A fetched opcode of 00000 (HALT) is delivered to IF/ID, leaves PC unchanged, sets halted=1 and enters HALTED; HALTED issues no requests.
REQ-023 Whenever no instruction is delivered and stall=0, IF/ID loads {NOP_INSTR, current value, valid=0}.
REQ-024 While stall=1, IF/ID and PC hold their values.
REQ-025 redirect=1 has priority over stall, ready and halt: PC becomes {redirect_pc[15:1],1'b0}, IF/ID is flushed to NOP with valid=0, the skid buffer and any outstanding WAIT are cancelled (a coincident imem_rdata is discarded), halted is cleared and the state becomes FETCH.
REQ-026 A redirect in WAIT deasserts imem_req for exactly one cycle before the new address is requested.

Reset
REQ-027 On rst_n=0, asynchronously and independent of clk: PC=RESET_PC, state=FETCH, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, halted=0, skid buffer empty.
REQ-028 imem_req is 0 while rst_n=0 and rises on the first edge after deassertion.
REQ-029 Reset asserted mid-WAIT abandons the fetch; a late imem_ready is ignored.

Structure
REQ-030 The shared opcodes package holds the HALT and NOP opcode constants, NOP_INSTR and the fetch state encoding.
REQ-031 One sub-module, pc_reg (16-bit register with load, hold and async active-low reset), is instantiated for the PC.

Verification
REQ-032 Reset, then imem_ready tied to 1 with instructions ADDI, XORI, LD -> ifid_pc_plus2 = 2, 4, 6 on consecutive cycles with ifid_valid=1.
REQ-033 stall=1 for 3 cycles while imem_ready=1 at PC=8 -> PC held at 8, IF/ID unchanged, the instruction appears from the skid buffer on the first unstalled cycle.
REQ-034 redirect=1 with redirect_pc=16'h0031 during WAIT -> imem_addr=16'h0030 after one idle cycle, ifid_valid=0, ifid_instr=16'h0800.
REQ-035 HALT fetched at PC=16'h0010 -> halted=1, imem_req=0 thereafter, PC stays 16'h0010; a later redirect to 16'h0040 clears halted and fetches from 16'h0040.
REQ-036 PC=16'hFFFE fetch completes -> PC=16'h0000 and ifid_pc_plus2=16'h0000.
REQ-037 rst_n pulsed low mid-WAIT with imem_ready=1 in the same cycle -> all outputs at reset values and the data is discarded.
